// File: rtl/led_pkg.sv
// Shared types and frame-word layout for the LED matrix scroll engine.
package led_pkg;

    localparam int FRAME_WORDS = 32;
    localparam int ROWS        = 8;
    localparam int DEVICES     = 4;
    localparam int COL_W       = 8;

    localparam int ROW_LSB  = 8;
    localparam int ROW_MSB  = 11;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    // Driver row registers are numbered 1..8, so the row field carries r+1.
    function automatic logic [15:0] make_word(input logic [2:0] row, input logic [7:0] data);
        logic [15:0] word;
        word                    = '0;
        word[ROW_MSB:ROW_LSB]   = {1'b0, row} + 4'd1;
        word[DATA_MSB:DATA_LSB] = data;
        return word;
    endfunction

endpackage

// File: rtl/led_col_ram.sv
// Column bitmap store: one byte per display column, synchronous write and read.
module led_col_ram
    import led_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [COL_W-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [COL_W-1:0]  rdata_o
);

    localparam int COL_DEPTH = 2 ** ADDR_W;

    logic [COL_W-1:0] mem_q [COL_DEPTH];
    logic [COL_W-1:0] rdata_q;

    // A same-address read and write in one cycle returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/led_scroll_engine.sv
// Renders a scrolling 32-column window of the column bitmap into the LED driver's
// frame RAM, kicks the driver, waits for it, then advances the scroll offset.
module led_scroll_engine
    import led_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [7:0]        in_col_data,
    input  logic [ADDR_W-1:0] in_col_addr,
    input  logic              in_col_we,
    input  logic [ADDR_W:0]   in_msg_len,
    input  logic              in_enable,
    input  logic [15:0]       in_hold,
    input  logic              in_drv_ready,
    output logic [15:0]       out_drv_data,
    output logic [4:0]        out_drv_addr,
    output logic              out_drv_we,
    output logic              out_drv_start,
    output logic [ADDR_W-1:0] out_offset,
    output logic              out_busy,
    output logic              out_frame_done
);

    localparam logic [ADDR_W:0] DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [4:0]      LAST_WORD = 5'(FRAME_WORDS - 1);

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
        return (len > DEPTH_L) ? DEPTH_L : len;
    endfunction

    function automatic logic [ADDR_W-1:0] start_offset(input logic [ADDR_W-1:0] base,
                                                       input logic [ADDR_W:0]   len);
        return ({1'b0, base} >= len) ? '0 : base;
    endfunction

    state_t            state_q;
    logic [4:0]        k_q;
    logic [3:0]        b_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W:0]   len_q;
    logic [15:0]       hold_q;
    logic [7:0]        shift_q;
    logic [15:0]       drv_data_q;
    logic [4:0]        drv_addr_q;
    logic              drv_we_q;
    logic              drv_start_q;
    logic              frame_done_q;

    logic              col_rd_en;
    logic [ADDR_W-1:0] col_rd_addr;
    logic [7:0]        col_rd_data;
    logic [ADDR_W:0]   rd_addr_inc;
    logic [ADDR_W-1:0] ptr_d;
    logic              cap_bit;
    logic [7:0]        shift_d;
    logic [ADDR_W:0]   off_inc;
    logic [ADDR_W-1:0] offset_adv_d;
    logic [ADDR_W:0]   len_d;

    // Each device's byte restarts from the offset only for device 0; devices
    // 1..3 continue from where the previous device's eight reads stopped.
    assign col_rd_addr = (b_q == 4'd0 && k_q[1:0] == 2'd0) ? offset_q : ptr_q;
    assign col_rd_en   = (state_q == S_FETCH) && (b_q < 4'd8) && (len_q != '0);
    assign rd_addr_inc = {1'b0, col_rd_addr} + 1'b1;
    assign ptr_d       = (rd_addr_inc >= len_q) ? '0 : rd_addr_inc[ADDR_W-1:0];

    assign cap_bit = col_rd_data[k_q[4:2]] & (len_q != '0);
    assign shift_d = {shift_q[6:0], cap_bit};

    assign off_inc      = {1'b0, offset_q} + 1'b1;
    assign offset_adv_d = (len_q == '0 || off_inc >= len_q) ? '0 : off_inc[ADDR_W-1:0];
    assign len_d        = clamp_len(in_msg_len);

    led_col_ram #(
        .ADDR_W (ADDR_W)
    ) u_col_ram (
        .clk_i   (in_clk),
        .we_i    (in_col_we),
        .waddr_i (in_col_addr),
        .wdata_i (in_col_data),
        .re_i    (col_rd_en),
        .raddr_i (col_rd_addr),
        .rdata_o (col_rd_data)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            b_q          <= '0;
            ptr_q        <= '0;
            offset_q     <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            shift_q      <= '0;
            drv_data_q   <= '0;
            drv_addr_q   <= '0;
            drv_we_q     <= 1'b0;
            drv_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            drv_we_q     <= 1'b0;
            drv_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_enable && in_drv_ready) begin
                        state_q  <= S_FETCH;
                        k_q      <= '0;
                        b_q      <= '0;
                        len_q    <= len_d;
                        offset_q <= start_offset(offset_q, len_d);
                    end
                end
                // b = 0..7 issue reads, b = 1..8 capture the previous read.
                S_FETCH: begin
                    if (col_rd_en) begin
                        ptr_q <= ptr_d;
                    end
                    if (b_q != 4'd0) begin
                        shift_q <= shift_d;
                    end
                    if (b_q == 4'd8) begin
                        state_q    <= S_WRITE;
                        drv_we_q   <= 1'b1;
                        drv_addr_q <= k_q;
                        drv_data_q <= make_word(k_q[4:2], shift_d);
                    end else begin
                        b_q <= b_q + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (k_q == LAST_WORD) begin
                        state_q     <= S_START;
                        drv_start_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        k_q     <= k_q + 5'd1;
                        b_q     <= '0;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!in_drv_ready) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (in_drv_ready) begin
                        state_q      <= S_HOLD;
                        frame_done_q <= 1'b1;
                        hold_q       <= in_hold;
                    end
                end
                S_HOLD: begin
                    if (hold_q == 16'd0) begin
                        if (in_enable) begin
                            state_q  <= S_FETCH;
                            k_q      <= '0;
                            b_q      <= '0;
                            len_q    <= len_d;
                            offset_q <= start_offset(offset_adv_d, len_d);
                        end else begin
                            state_q  <= S_IDLE;
                            offset_q <= offset_adv_d;
                        end
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_drv_data   = drv_data_q;
    assign out_drv_addr   = drv_addr_q;
    assign out_drv_we     = drv_we_q;
    assign out_drv_start  = drv_start_q;
    assign out_offset     = offset_q;
    assign out_busy       = (state_q != S_IDLE);
    assign out_frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scroll_engine.sv
// Directed bench for led_scroll_engine with a behavioural LED driver model.
module tb_led_scroll_engine;
    import led_pkg::*;

    localparam int ADDR_W = 8;

    logic              in_clk = 1'b0;
    logic              in_rst = 1'b1;
    logic [7:0]        in_col_data = '0;
    logic [ADDR_W-1:0] in_col_addr = '0;
    logic              in_col_we = 1'b0;
    logic [ADDR_W:0]   in_msg_len = '0;
    logic              in_enable = 1'b0;
    logic [15:0]       in_hold = '0;
    logic              in_drv_ready;
    logic [15:0]       out_drv_data;
    logic [4:0]        out_drv_addr;
    logic              out_drv_we;
    logic              out_drv_start;
    logic [ADDR_W-1:0] out_offset;
    logic              out_busy;
    logic              out_frame_done;

    led_scroll_engine #(.ADDR_W(ADDR_W)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_col_data    (in_col_data),
        .in_col_addr    (in_col_addr),
        .in_col_we      (in_col_we),
        .in_msg_len     (in_msg_len),
        .in_enable      (in_enable),
        .in_hold        (in_hold),
        .in_drv_ready   (in_drv_ready),
        .out_drv_data   (out_drv_data),
        .out_drv_addr   (out_drv_addr),
        .out_drv_we     (out_drv_we),
        .out_drv_start  (out_drv_start),
        .out_offset     (out_offset),
        .out_busy       (out_busy),
        .out_frame_done (out_frame_done)
    );

    always #5 in_clk = ~in_clk;

    // Driver model: ready drops 3 cycles after start and returns 100 cycles later.
    int          drv_cnt = 0;
    int          nwrites = 0;
    int          nstarts = 0;
    logic [15:0] frame [32];
    assign in_drv_ready = (drv_cnt < 3);

    always @(posedge in_clk) begin
        if (out_drv_we) begin
            frame[out_drv_addr] <= out_drv_data;
            nwrites <= nwrites + 1;
        end
        if (out_drv_start) begin
            nstarts <= nstarts + 1;
            drv_cnt <= 1;
        end else if (drv_cnt != 0) begin
            drv_cnt <= (drv_cnt >= 102) ? 0 : drv_cnt + 1;
        end
    end

    logic [7:0] shadow [256];
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          k;
        logic [15:0] exp;
    } wvec_t;
    wvec_t t2v [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT event", name);
    endtask

    function automatic logic [15:0] model_word(input int k, input int off, input int len);
        logic [7:0] d;
        int r;
        int dev;
        d   = '0;
        r   = k / 4;
        dev = k % 4;
        for (int j = 0; j < 8; j++) begin
            if (len != 0) d[7-j] = shadow[(off + 8*dev + j) % len][r];
        end
        return {4'h0, 4'(r + 1), d};
    endfunction

    task automatic write_col(input int addr, input logic [7:0] data);
        @(negedge in_clk);
        in_col_we   = 1'b1;
        in_col_addr = ADDR_W'(addr);
        in_col_data = data;
        shadow[addr] = data;
        @(negedge in_clk);
        in_col_we = 1'b0;
    endtask

    task automatic wait_we0(input int exp_off);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge in_clk);
            if (out_drv_we && out_drv_addr == 5'd0) seen = 1'b1;
        end
        if (!seen) timeout("first_write");
        else check("frame_offset", 32'(out_offset), 32'(exp_off));
    endtask

    task automatic finish_frame(input int exp_off, input int len);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge in_clk);
            if (out_frame_done) seen = 1'b1;
        end
        if (!seen) begin
            timeout("frame_done");
        end else begin
            for (int k = 0; k < 32; k++)
                check($sformatf("word%0d_off%0d_len%0d", k, exp_off, len),
                      32'(frame[k]), 32'(model_word(k, exp_off, len)));
        end
    endtask

    task automatic run_frame(input int exp_off, input int len);
        wait_we0(exp_off);
        finish_frame(exp_off, len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s;
        bit seen;
        t2v[0] = '{0,  16'h0180};
        t2v[1] = '{1,  16'h0100};
        t2v[2] = '{4,  16'h0200};
        t2v[3] = '{2,  16'h0100};
        t2v[4] = '{8,  16'h0300};
        t2v[5] = '{31, 16'h0800};

        // Reset state
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        in_rst = 1'b0;
        check("rst_we", 32'(out_drv_we), 0);
        check("rst_start", 32'(out_drv_start), 0);
        check("rst_busy", 32'(out_busy), 0);
        check("rst_done", 32'(out_frame_done), 0);
        check("rst_offset", 32'(out_offset), 0);
        check("rst_addr", 32'(out_drv_addr), 0);
        check("rst_data", 32'(out_drv_data), 0);

        for (int a = 0; a < 256; a++) write_col(a, 8'h00);
        write_col(0, 8'h01);
        check("idle_after_load", 32'(out_busy), 0);

        // Basic frame: len 32, offset 0, first-write latency and driver handshake
        @(negedge in_clk);
        in_msg_len = 9'd32;
        in_hold    = 16'd4;
        in_enable  = 1'b1;
        repeat (9) @(posedge in_clk);
        #1 check("we_before_10", 32'(out_drv_we), 0);
        @(posedge in_clk);
        #1;
        check("we_at_10", 32'(out_drv_we), 1);
        check("addr_at_10", 32'(out_drv_addr), 0);
        check("data_at_10", 32'(out_drv_data), 32'h0180);
        check("busy_running", 32'(out_busy), 1);
        finish_frame(0, 32);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_word%0d", t2v[i].k), 32'(frame[t2v[i].k]), 32'(t2v[i].exp));
        check("one_start", 32'(nstarts), 1);
        check("writes_frame1", 32'(nwrites), 32);
        repeat (4) @(posedge in_clk);
        #1 check("offset_in_hold", 32'(out_offset), 0);
        @(posedge in_clk);
        #1;
        check("offset_after_hold", 32'(out_offset), 1);
        check("busy_after_hold", 32'(out_busy), 1);
        repeat (8) @(posedge in_clk);
        #1 check("we2_early", 32'(out_drv_we), 0);
        @(posedge in_clk);
        #1;
        check("we2_on_time", 32'(out_drv_we), 1);
        check("we2_data", 32'(out_drv_data), 32'h0100);

        // len 5: wrapping columns and offset sequence 0,1,2,3,4,0
        @(negedge in_clk);
        in_rst     = 1'b1;
        in_msg_len = 9'd5;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        in_rst = 1'b0;
        check("len5_word0_model", 32'(model_word(0, 0, 5)), 32'h0184);
        for (int f = 0; f < 6; f++) run_frame(f % 5, 5);

        // Reset in the middle of a frame
        in_msg_len = 9'd32;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge in_clk);
            if (out_drv_we && out_drv_addr == 5'd10) seen = 1'b1;
        end
        if (!seen) timeout("word10");
        check("pre_reset_offset", 32'(out_offset), 1);
        in_rst = 1'b1;
        @(posedge in_clk);
        #1;
        check("midrst_we", 32'(out_drv_we), 0);
        check("midrst_start", 32'(out_drv_start), 0);
        check("midrst_busy", 32'(out_busy), 0);
        check("midrst_offset", 32'(out_offset), 0);
        check("midrst_addr", 32'(out_drv_addr), 0);
        @(negedge in_clk);
        in_rst = 1'b0;
        run_frame(0, 32);
        check("retained_word0", 32'(frame[0]), 32'h0180);

        // len 0: blank frames, offset pinned at 0
        in_msg_len = 9'd0;
        run_frame(0, 0);
        run_frame(0, 0);

        // Enable dropped during FETCH: frame completes, offset advances, then idle
        in_msg_len = 9'd32;
        wait_we0(0);
        @(negedge in_clk);
        in_enable = 1'b0;
        finish_frame(0, 32);
        repeat (4) @(posedge in_clk);
        #1 check("drop_busy_hold", 32'(out_busy), 1);
        @(posedge in_clk);
        #1;
        check("drop_offset", 32'(out_offset), 1);
        check("drop_busy_idle", 32'(out_busy), 0);
        w = nwrites;
        s = nstarts;
        repeat (60) @(posedge in_clk);
        #1;
        check("drop_no_writes", 32'(nwrites), 32'(w));
        check("drop_no_starts", 32'(nstarts), 32'(s));
        check("drop_still_idle", 32'(out_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_scroll_engine.md
# led_scroll_engine

Frame generator directly upstream of the 32x8 LED matrix SPI driver. Holds a CPU-written column bitmap (one byte per display column), renders a 32-column window at a scrolling offset into the driver's 32-word frame RAM, pulses the driver's start input, waits for frame completion, then advances the offset. The CPU therefore loads a message once and the matrix scrolls without further CPU traffic.

## Interface
- ADDR_W, 8: column-memory address width; COL_DEPTH = 2**ADDR_W columns.
- in_clk  in  1  single clock; shared with the LED driver.
- in_rst  in  1  reset, synchronous, active-high.
- in_col_data  in  8  column bitmap; bit r = row r (row 0 top).
- in_col_addr  in  ADDR_W  column write address.
- in_col_we  in  1  column memory write enable.
- in_msg_len  in  ADDR_W+1  valid columns; values > COL_DEPTH clamp to COL_DEPTH; 0 = blank.
- in_enable  in  1  run scrolling.
- in_hold  in  16  extra idle cycles between frames.
- in_drv_ready  in  1  driver out_IR_READY.
- out_drv_data  out  16  frame word to driver in_data.
- out_drv_addr  out  5  driver in_addr.
- out_drv_we  out  1  driver in_we.
- out_drv_start  out  1  driver in_IR_START, one-cycle pulse.
- out_offset  out  ADDR_W  current leftmost column index.
- out_busy  out  1  high in any state but IDLE.
- out_frame_done  out  1  one-cycle pulse when driver finishes a frame.

## Operation
- Frame word k (0..31): row r = k[4:2], device d = k[1:0]; word = {4'h0, r+1 (4 bits), data[7:0]}. data bit 7 = display column 8d, bit 0 = column 8d+7; bit value = row r of column (offset + 8d + j) mod len.
- Column pointer: reset to offset at every word with d=0, increments per read, wraps to 0 at len. len == 0: no reads, data forced 8'h00.
- len latched at every frame start; if offset >= latched len, offset forced to 0 first.
- States: IDLE -> FETCH when in_enable && in_drv_ready. FETCH: step b=0..8, issue column reads b=0..7, capture b=1..8 -> WRITE. WRITE: out_drv_we=1 one cycle, addr=k; k<31 -> FETCH (k+1), else -> START. START: out_drv_start=1 one cycle -> WAIT_ACK. WAIT_ACK: until in_drv_ready==0 -> WAIT_DONE. WAIT_DONE: until in_drv_ready==1, then out_frame_done pulse -> HOLD. HOLD: in_hold+1 cycles (in_hold latched on entry); on exit offset <= (offset+1) mod len (0 if len==0); in_enable ? FETCH : IDLE.
- Driver RAM is written only while driver ready is high (before START).
- Column RAM writes are accepted in every state; same-address read/write returns old data; a mid-frame write may tear one frame (accepted).
- in_enable deasserted mid-frame: frame completes through HOLD, offset advances, then IDLE.

## Timing
- Reset values: all outputs 0; out_offset 0; state IDLE; k, b cleared. Column RAM not cleared.
- Column RAM: synchronous read, 1-cycle latency.
- Per word 10 cycles (9 FETCH + 1 WRITE); first out_drv_we 10 cycles after the IDLE cycle sampling enable&&ready; 32 writes at 10-cycle spacing; out_drv_start the cycle after the 32nd WRITE.
- Reset mid-operation: next cycle out_drv_we/out_drv_start low, state IDLE, offset 0.
- out_drv_data/out_drv_addr hold last value outside WRITE.

## Structure
- Package led_pkg: state encoding, FRAME_WORDS=32, ROWS=8, DEVICES=4, word-field positions (row field [11:8], data [7:0]).
- Sub-module led_col_ram: COL_DEPTH x 8, sync write, sync read, parameter ADDR_W.

## Test plan
- col0=8'h01, rest 0, len=32, offset 0 -> word0=16'h0180, word4=16'h0200, word1=16'h0100, all others data 0.
- Driver model: ready drops 3 cycles after start, rises 100 later, in_hold=4 -> exactly one start pulse, frame_done on rise, offset=1 five cycles later, next FETCH begins.
- len=5, col0=8'h01 -> word0=16'h0184; offset sequence 0,1,2,3,4,0 over six frames.
- len=0 -> all 32 words data 8'h00, offset remains 0.
- in_rst at word 10 -> next cycle we=0, start=0, busy=0, offset 0; re-enable -> word0 correct (RAM retained).
- in_enable drop during FETCH -> frame finishes, offset +1, IDLE, busy=0, no further writes.
